pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the fixed-field per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block. It adds a valid bit, hold (stall), flush, bubble insertion that preserves PC and delay-slot information for precise exceptions, and exception-code transport. It also keeps saturating stall/bubble/flush event counters for performance debug. One instance sits between each pair of adjacent stages.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/sat_counter.sv | 12 +
 rtl/pipe_stage_reg.sv | 63 ++++++
 tb/tb_pipe_stage_reg.sv | 112 +++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the MIPS inter-stage pipeline registers.
package pipe_pkg;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP = 32'h0;
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP = 5'd9;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    count <= reset ? '0 : (inc && count != '1) ? count + 1'b1 : count;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with hold, flush, PC-preserving
// bubble insertion, exception transport and saturating event counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 96,
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic              in_bd,
  input  logic [4:0]        in_exc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic              out_bd,
  output logic [4:0]        out_exc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic stall_inc, bubble_inc, flush_inc;
  // Each counter sees only the action that actually won the priority race.
  assign flush_inc  = !reset && flush;
  assign bubble_inc = !reset && !flush && bubble;
  assign stall_inc  = !reset && !flush && !bubble && !en;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_pc    <= PC_RESET;
      out_instr <= INSTR_NOP;
      out_bd    <= 1'b0;
      out_exc   <= EXC_NONE;
      out_data  <= '0;
    end else if (bubble) begin
      out_valid <= 1'b0;
      out_pc    <= in_pc;
      out_instr <= INSTR_NOP;
      out_bd    <= in_bd;
      out_exc   <= EXC_NONE;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_pc    <= in_pc;
      out_instr <= in_instr;
      out_bd    <= in_bd;
      out_exc   <= in_exc;
      out_data  <= in_data;
    end
  end
  sat_counter #(.W(CNT_W)) u_stall  (.clk(clk), .reset(reset), .inc(stall_inc),  .count(stall_cnt));
  sat_counter #(.W(CNT_W)) u_bubble (.clk(clk), .reset(reset), .inc(bubble_inc), .count(bubble_cnt));
  sat_counter #(.W(CNT_W)) u_flush  (.clk(clk), .reset(reset), .inc(flush_inc),  .count(flush_cnt));
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vectors with hand-computed expectations, checked by a scoreboard monitor.
module tb_pipe_stage_reg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic [4:0]  exc;
    logic [95:0] data;
    logic [15:0] s;
    logic [15:0] b;
    logic [15:0] f;
    logic [1:0]  s2;
  } exp_t;
  logic clk = 0, reset = 0, en = 0, flush = 0, bubble = 0, in_valid = 0, in_bd = 0;
  logic [31:0] in_pc = 0, in_instr = 0;
  logic [4:0] in_exc = 0;
  logic [95:0] in_data = 0;
  logic out_valid, out_bd, out_valid2, out_bd2;
  logic [31:0] out_pc, out_instr, out_pc2, out_instr2;
  logic [4:0] out_exc, out_exc2;
  logic [95:0] out_data, out_data2;
  logic [15:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [1:0] stall_cnt2, bubble_cnt2, flush_cnt2;
  exp_t q[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd), .in_exc(in_exc), .in_data(in_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_bd(out_bd), .out_exc(out_exc), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));
  pipe_stage_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .bubble(bubble),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_bd(in_bd), .in_exc(in_exc), .in_data(in_data),
    .out_valid(out_valid2), .out_pc(out_pc2), .out_instr(out_instr2), .out_bd(out_bd2), .out_exc(out_exc2), .out_data(out_data2),
    .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2), .flush_cnt(flush_cnt2));
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("out_valid", 128'(out_valid), 128'(e.valid));
      chk("out_pc", 128'(out_pc), 128'(e.pc));
      chk("out_instr", 128'(out_instr), 128'(e.instr));
      chk("out_bd", 128'(out_bd), 128'(e.bd));
      chk("out_exc", 128'(out_exc), 128'(e.exc));
      chk("out_data", 128'(out_data), 128'(e.data));
      chk("stall_cnt", 128'(stall_cnt), 128'(e.s));
      chk("bubble_cnt", 128'(bubble_cnt), 128'(e.b));
      chk("flush_cnt", 128'(flush_cnt), 128'(e.f));
      chk("stall_cnt_w2", 128'(stall_cnt2), 128'(e.s2));
    end
  end
  function automatic exp_t mk(input logic v, input logic [31:0] pc, ins, input logic bd, input logic [4:0] x,
                              input logic [95:0] d, input logic [15:0] s, b, f, input logic [1:0] s2);
    mk = '{valid: v, pc: pc, instr: ins, bd: bd, exc: x, data: d, s: s, b: b, f: f, s2: s2};
  endfunction
  task automatic vec(input logic r, e, fl, bu, v, input logic [31:0] pc, ins, input logic bd,
                     input logic [4:0] x, input logic [95:0] d, input exp_t ex);
    @(negedge clk);
    reset = r; en = e; flush = fl; bubble = bu; in_valid = v;
    in_pc = pc; in_instr = ins; in_bd = bd; in_exc = x; in_data = d;
    q.push_back(ex);
  endtask
  localparam logic [95:0] D1 = 96'hA1, D2 = 96'hB2_0000_0000_0000_0000_00C3, D3 = 96'hDEAD, D4 = 96'hFFFF_0000_0000_0000_0000_0004;
  initial begin
    // reset, and reset beating a stall
    vec(1,1,0,0,1, 32'h5000, 32'h77, 1, 5'd3, D3, mk(0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0));
    vec(1,0,1,1,1, 32'h5004, 32'h78, 1, 5'd3, D3, mk(0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0));
    // loads
    vec(0,1,0,0,1, 32'h3004, 32'h8C01_0000, 0, 0, D1, mk(1, 32'h3004, 32'h8C01_0000, 0, 0, D1, 0, 0, 0, 0));
    vec(0,1,0,0,1, 32'h3008, 32'h1111_1111, 0, 0, D2, mk(1, 32'h3008, 32'h1111_1111, 0, 0, D2, 0, 0, 0, 0));
    // five stalls with changing inputs; the 2-bit counter saturates at 3
    vec(0,0,0,0,0, 32'h4000, 32'h1, 1, 5'd4, D3, mk(1, 32'h3008, 32'h1111_1111, 0, 0, D2, 1, 0, 0, 1));
    vec(0,0,0,0,1, 32'h4004, 32'h2, 0, 5'd5, D1, mk(1, 32'h3008, 32'h1111_1111, 0, 0, D2, 2, 0, 0, 2));
    vec(0,0,0,0,1, 32'h4008, 32'h3, 1, 5'd8, D4, mk(1, 32'h3008, 32'h1111_1111, 0, 0, D2, 3, 0, 0, 3));
    vec(0,0,0,0,0, 32'h400C, 32'h4, 0, 5'd9, D3, mk(1, 32'h3008, 32'h1111_1111, 0, 0, D2, 4, 0, 0, 3));
    vec(0,0,0,0,1, 32'h4010, 32'h5, 1, 5'd12, D1, mk(1, 32'h3008, 32'h1111_1111, 0, 0, D2, 5, 0, 0, 3));
    // bubble keeps pc/bd only
    vec(0,1,0,1,1, 32'h300C, 32'h1234, 1, 5'd3, D3, mk(0, 32'h300C, 0, 1, 0, 0, 5, 1, 0, 3));
    // flush + bubble + stall: flush wins
    vec(0,0,1,1,1, 32'h6000, 32'h99, 1, 5'd4, D4, mk(0, 32'h3000, 0, 0, 0, 0, 5, 1, 1, 3));
    // exception transport then flush
    vec(0,1,0,0,1, 32'h3010, 32'h0000_000C, 1, 5'd10, D4, mk(1, 32'h3010, 32'h0000_000C, 1, 5'd10, D4, 5, 1, 1, 3));
    vec(0,1,1,0,1, 32'h3014, 32'h55, 0, 5'd4, D1, mk(0, 32'h3000, 0, 0, 0, 0, 5, 1, 2, 3));
    // invalid load is not counted as a bubble
    vec(0,1,0,0,0, 32'h3014, 32'h5, 0, 0, D1, mk(0, 32'h3014, 32'h5, 0, 0, D1, 5, 1, 2, 3));
    // bubble beats stall
    vec(0,0,0,1,1, 32'h3018, 32'h66, 0, 5'd9, D2, mk(0, 32'h3018, 0, 0, 0, 0, 5, 2, 2, 3));
    // stall, reset mid-stall, then stall again counts from 0
    vec(0,0,0,0,1, 32'h7000, 32'h1, 0, 0, D1, mk(0, 32'h3018, 0, 0, 0, 0, 6, 2, 2, 3));
    vec(1,0,0,0,1, 32'h7004, 32'h2, 1, 0, D1, mk(0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0));
    vec(0,0,0,0,1, 32'h7008, 32'h3, 1, 5'd4, D2, mk(0, 32'h3000, 0, 0, 0, 0, 1, 0, 0, 1));
    vec(0,0,0,0,1, 32'h700C, 32'h4, 0, 0, D3, mk(0, 32'h3000, 0, 0, 0, 0, 2, 0, 0, 2));
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
